sc_stream_gen: RTL

//  Binary-to-stochastic encoder. Converts a WIDTH-bit unsigned value into a unipolar

---
 rtl/sc_stream_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/sc_stream_gen.sv
// Binary-to-stochastic encoder: compares a held value against an LFSR sample to emit a unipolar bitstream.
// Optional build macro SC_EXT_RAND_EN replaces the internal LFSR with an external randnum input.
module sc_stream_gen #(
   parameter int               WIDTH = 8,
   parameter int               LEN_W = 16,
   parameter logic [WIDTH-1:0] SEED  = 8'hAD,
   parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reseed,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LEN_W-1:0] in_len,
   output logic             bit_valid,
   input  logic             bit_ready,
   output logic             bit_out,
   output logic             done
`ifdef SC_EXT_RAND_EN
   ,
   input  logic [WIDTH-1:0] randnum
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] data_q;
   logic [LEN_W-1:0] rem;
   logic [WIDTH-1:0] rnd;
   logic             bit_hs;

   function automatic logic above_rnd(input logic [WIDTH-1:0] val, input logic [WIDTH-1:0] r);
      return val > r;
   endfunction

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
      return (v >> 1) ^ (v[0] ? TAPS : '0);
   endfunction

   assign bit_hs = bit_valid && bit_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         data_q    <= '0;
         rem       <= '0;
         in_ready  <= 1'b1;
         bit_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_q   <= in_data;
                  rem      <= in_len;
                  in_ready <= 1'b0;
                  if (in_len != '0) begin
                     state     <= RUN;
                     bit_valid <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (bit_hs) begin
                  rem <= rem - LEN_W'(1);
                  // Exit on the last handshake so a full-scale length never wraps.
                  if (rem == LEN_W'(1)) begin
                     state     <= DONE;
                     bit_valid <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               done     <= 1'b0;
               in_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               bit_valid <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

`ifdef SC_EXT_RAND_EN
   logic unused_reseed;
   assign unused_reseed = reseed;
   assign rnd = randnum;
`else
   logic [WIDTH-1:0] lfsr;

   // Advances only on a bit handshake, so stalls hold the sample and bit_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= SEED;
      end else if (state == IDLE && reseed) begin
         lfsr <= SEED;
      end else if (bit_hs) begin
         lfsr <= lfsr_step(lfsr);
      end
   end

   // LFSR spans 1..2^WIDTH-1; shifting down gives a uniform 0..2^WIDTH-2 threshold.
   assign rnd = lfsr - WIDTH'(1);
`endif

   assign bit_out = above_rnd(data_q, rnd) & bit_valid;

endmodule
